// File: rtl/addr_sequencer_pkg.sv
// Shared definitions for the address sequencer: FSM state encoding and the
// legal range of the output delay line depth.
package addr_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  localparam int DELAY_MIN = 1;
  localparam int DELAY_MAX = 4;

  // Force a requested delay into the supported range so an out-of-range
  // parameter still builds a sensible pipeline.
  function automatic int clamp_delay(input int d);
    if (d < DELAY_MIN) return DELAY_MIN;
    if (d > DELAY_MAX) return DELAY_MAX;
    return d;
  endfunction

endpackage

// File: rtl/addr_sequencer_pipe.sv
// Output delay line carrying {valid, last, addr}. Valid bits shift every
// cycle; payload only moves with a valid beat so the final stage keeps its
// last address while the line is empty. clr drops every in-flight beat.
module addr_seq_pipe #(
  parameter int W     = 7,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [W-1:0] in_addr,
  output logic         out_valid,
  output logic         out_last,
  output logic [W-1:0] out_addr
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] l_q;
  logic [W-1:0]     a_q [DEPTH];

  // Shift stages; payload advances only alongside a valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      l_q <= '0;
      for (int i = 0; i < DEPTH; i++) a_q[i] <= '0;
    end else begin
      v_q[0] <= clr ? 1'b0 : in_valid;
      if (!clr && in_valid) begin
        l_q[0] <= in_last;
        a_q[0] <= in_addr;
      end
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= clr ? 1'b0 : v_q[i-1];
        if (!clr && v_q[i-1]) begin
          l_q[i] <= l_q[i-1];
          a_q[i] <= a_q[i-1];
        end
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_last  = l_q[DEPTH-1];
  assign out_addr  = a_q[DEPTH-1];

endmodule

// File: rtl/addr_sequencer.sv
// Strided address sequencer: issues len beats starting at base, stepping by
// stride, either once (then drains the output pipe) or repeatedly.
// Handshake: en_i is a plain advance strobe with no back-pressure; a beat is
// issued on every clock edge where the FSM is in RUN, en_i=1 and abort_i=0,
// and it appears on valid_o/cnt_o/last_o after DELAY register stages.
module addr_sequencer
  import addr_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 7,
  parameter int DELAY     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] base_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic [CNT_WIDTH-1:0] stride_i,
  input  logic                 wrap_i,
  input  logic                 en_i,
  input  logic                 abort_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 valid_o,
  output logic                 last_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam int STAGES = clamp_delay(DELAY);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  seq_state_e state_q, state_d;
  cnt_t       base_q, len_q, stride_q;
  logic       wrap_q;
  cnt_t       addr_q, addr_d, idx_q, idx_d;
  logic       accept, issue, issue_last, flush;
  logic       pipe_valid, pipe_last;
  cnt_t       pipe_addr;

  // Next-state, address/index update and beat issue.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    accept     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && (len_i != '0)) begin
          accept  = 1'b1;
          addr_d  = base_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (en_i) begin
          issue      = 1'b1;
          issue_last = (idx_q == (len_q - cnt_t'(1)));
          addr_d     = addr_q + stride_q;
          idx_d      = idx_q + cnt_t'(1);
          if (issue_last) begin
            if (wrap_q) begin
              addr_d = base_q;
              idx_d  = '0;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (abort_i) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (done_o) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the parameters captured at an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      stride_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      if (accept) begin
        base_q   <= base_i;
        len_q    <= len_i;
        stride_q <= stride_i;
        wrap_q   <= wrap_i;
      end
    end
  end

  addr_seq_pipe #(
    .W     (CNT_WIDTH),
    .DEPTH (STAGES)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .in_valid  (issue),
    .in_last   (issue_last),
    .in_addr   (addr_q),
    .out_valid (pipe_valid),
    .out_last  (pipe_last),
    .out_addr  (pipe_addr)
  );

  // The pipe is empty whenever a new start can be accepted, so wrap_q still
  // describes the sequence whose beats are leaving the pipe.
  assign cnt_o   = pipe_addr;
  assign valid_o = pipe_valid;
  assign last_o  = pipe_valid & pipe_last;
  assign done_o  = pipe_valid & pipe_last & ~wrap_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: doc/addr_sequencer.md
ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 Parameter CNT_WIDTH, default 7, SHALL set the address, length and stride width (100-entry buffers fit in 2^7).
REQ-002 Parameter DELAY, default 1, legal range 1..4, SHALL set the number of output register stages.
REQ-003 Ports SHALL be exactly:
  clk       in   1          sole clock, rising edge
  rst       in   1          synchronous, active-high reset
  start_i   in   1          pulse: launch a sequence (honoured only in IDLE)
  base_i    in   CNT_WIDTH  first address, sampled on accepted start
  len_i     in   CNT_WIDTH  beats per pass, sampled on accepted start
  stride_i  in   CNT_WIDTH  address increment, sampled on accepted start
  wrap_i    in   1          0 = one-shot, 1 = continuous; sampled on accepted start
  en_i      in   1          advance one beat this cycle
  abort_i   in   1          terminate the sequence immediately
  cnt_o     out  CNT_WIDTH  issued address, delayed DELAY cycles
  valid_o   out  1          cnt_o carries a beat this cycle
  last_o    out  1          beat is the final one of a pass
  done_o    out  1          one-cycle completion pulse
  busy_o    out  1          a sequence is running or draining
REQ-004 There SHALL be one clock and one reset; the reset is synchronous and active-high.

Function
REQ-005 The FSM SHALL have the states IDLE, RUN and DRAIN.
REQ-006 In IDLE, start_i=1 with len_i!=0 SHALL latch base, len, stride and wrap, clear the beat index, load addr=base_i and enter RUN.
REQ-007 In IDLE, start_i=1 with len_i==0 SHALL be ignored, and start_i SHALL be ignored in RUN and DRAIN.
REQ-008 In RUN with en_i=1 the block SHALL issue one beat {addr, last=(idx==len-1)}, then set addr=addr+stride mod 2^CNT_WIDTH and idx=idx+1.
REQ-009 In RUN with en_i=0 the block SHALL hold addr and idx and issue nothing.
REQ-010 For a last beat in one-shot mode, the FSM SHALL go to DRAIN.
REQ-011 For a last beat in wrap mode, the block SHALL reload addr=base and idx=0 and stay in RUN.
REQ-012 Each issued beat SHALL appear on cnt_o, valid_o and last_o exactly DELAY cycles after the en_i edge, with no beat dropped or duplicated.
REQ-013 done_o SHALL equal valid_o & last_o & one-shot, so it pulses coincident with the final output beat.
REQ-014 The FSM SHALL leave DRAIN for IDLE on the cycle done_o is asserted.
REQ-015 busy_o SHALL be high in RUN and DRAIN and low in IDLE.
REQ-016 abort_i=1 in RUN or DRAIN SHALL return the FSM to IDLE and clear all pipeline valid bits at the next edge, and done_o SHALL NOT assert for that sequence.
REQ-017 abort_i SHALL take priority over en_i, and abort_i in IDLE SHALL have no effect.
REQ-018 When the pipeline holds no beat, cnt_o SHALL retain its last value, and cnt_o SHALL be don't-care when valid_o=0.
REQ-019 A start accepted in the cycle after the FSM returns to IDLE SHALL be honoured, giving a back-to-back restart with no idle gap on busy_o beyond one cycle.

Reset
REQ-020 rst=1 SHALL force IDLE, idx=0, addr=0, all pipeline stages invalid, cnt_o=0, valid_o=0, last_o=0, done_o=0 and busy_o=0 at the next edge.
REQ-021 rst SHALL override start_i, en_i and abort_i, including reset asserted mid-sequence.

Structure
REQ-022 A shared package SHALL hold the FSM state enum (IDLE, RUN, DRAIN) and the DELAY range limits.
REQ-023 The output delay line SHALL be a sub-module, addr_seq_pipe, parametrised by width and DELAY, carrying {valid, last, addr} with synchronous clear and reset.

Verification
REQ-024 Bench scenarios SHALL be:
  - One-shot, DELAY=1, base=10, len=4, stride=3, en_i held high -> cnt_o 10,13,16,19 on consecutive cycles; last_o and done_o high with 19; busy_o low on the next cycle.
  - CNT_WIDTH=7, base=120, len=3, stride=5 -> cnt_o 120,125,2 (mod 128 wrap-around).
  - Wrap mode, base=0, len=2, stride=1, 6 enables -> cnt_o 0,1,0,1,0,1; last_o on every 1; done_o never asserts.
  - en_i toggling 1,0,0,1,1, len=3, DELAY=3 -> three beats, each exactly 3 cycles after its enable; gaps preserved.
  - abort_i after the 2nd of len=5 beats, DELAY=2 -> at most one further valid_o beat (the one already at the output register), then none; done_o=0; busy_o low next cycle.
  - start_i with len_i=0 -> busy_o stays 0; start_i during RUN -> latched values unchanged; rst mid-RUN -> all outputs 0 next cycle.
